// File: rtl/wbs_mem_ctrl.sv
// wbs_mem_ctrl: Wishbone-slave front end of the ANN accelerator.
// Decodes single-beat classic Wishbone cycles into the control and status
// registers, the node/leaf/query SRAM write ports and the best-match SRAM
// read port. It packs two 32-bit writes into one leaf/query entry and issues
// the one-cycle fsm_start pulse.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wbs_*_i / wbs_*_o   Wishbone slave (wbs_sel_i ignored, full-word only)
//   node_*              node SRAM write port  (wdata = {median, index})
//   leaf_*              leaf SRAM write port  (64-bit entries)
//   query_*             query SRAM write port (55-bit entries)
//   best_*              best-match SRAM read port (data 1 cycle after ren)
//   mode, debug         control register bits
//   fsm_start           start pulse to the search FSM
//   fsm_busy, fsm_done  search FSM status
//
// state   | meaning
// IDLE    | wait for a fresh request, capture adr/dat/we
// EXEC    | perform the access (SRAM strobe / register update / start pulse)
// RD_WAIT | best SRAM read in flight, capture best_rdata
// ACK     | ack high for one cycle with read data
`timescale 1ns/1ps
module wbs_mem_ctrl #(
  parameter int          DATA_WIDTH     = 11,
  parameter int          NUM_LEAVES     = 64,
  parameter int          NUM_QUERYS     = 494,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
  parameter logic [31:0] MODE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] DEBUG_ADDR     = 32'h3000_0004,
  parameter logic [31:0] DONE_ADDR      = 32'h3000_0008,
  parameter logic [31:0] FSM_START_ADDR = 32'h3000_000C,
  parameter logic [31:0] FSM_BUSY_ADDR  = 32'h3000_0010,
  parameter logic [31:0] QUERY_BASE     = 32'h3001_0000,
  parameter logic [31:0] LEAF_BASE      = 32'h3002_0000,
  parameter logic [31:0] BEST_BASE      = 32'h3003_0000,
  parameter logic [31:0] NODE_BASE      = 32'h3004_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  node_wen,
  output logic [5:0]            node_waddr,
  output logic [21:0]           node_wdata,
  output logic                  leaf_wen,
  output logic [8:0]            leaf_waddr,
  output logic [63:0]           leaf_wdata,
  output logic                  query_wen,
  output logic [8:0]            query_waddr,
  output logic [54:0]           query_wdata,
  output logic                  best_ren,
  output logic [8:0]            best_raddr,
  input  logic [DATA_WIDTH-1:0] best_rdata,
  output logic                  mode,
  output logic                  debug,
  output logic                  fsm_start,
  input  logic                  fsm_busy,
  input  logic                  fsm_done
);

  localparam int LEAF_ENTRIES = NUM_LEAVES * 8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RD_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] lower_q, lower_d;
  logic        mode_q, mode_d;
  logic        debug_q, debug_d;
  // Set once a request has been acked; blocks re-service until stb drops.
  logic        served_q, served_d;

  logic        in_query, in_leaf, in_best, in_node;
  logic [12:0] ent_idx;
  logic [13:0] best_idx;
  logic        leaf_ok, query_ok, best_ok, node_ok;
  logic [63:0] entry_word;
  logic        unused_sel;

  assign unused_sel = &{1'b0, wbs_sel_i};

  assign in_query = (adr_q & ADDR_MASK) == QUERY_BASE;
  assign in_leaf  = (adr_q & ADDR_MASK) == LEAF_BASE;
  assign in_best  = (adr_q & ADDR_MASK) == BEST_BASE;
  assign in_node  = (adr_q & ADDR_MASK) == NODE_BASE;

  // Leaf/query entries are 8 bytes wide, best entries are one word.
  assign ent_idx  = adr_q[15:3];
  assign best_idx = adr_q[15:2];
  assign leaf_ok  = ent_idx < 13'(LEAF_ENTRIES);
  assign query_ok = ent_idx < 13'(NUM_QUERYS);
  assign best_ok  = best_idx < 14'(NUM_QUERYS);
  assign node_ok  = adr_q[15:0] < 16'(NUM_LEAVES);

  assign entry_word  = {dat_q, lower_q};
  assign node_waddr  = adr_q[5:0];
  assign node_wdata  = dat_q[21:0];
  assign leaf_waddr  = ent_idx[8:0];
  assign leaf_wdata  = entry_word;
  assign query_waddr = ent_idx[8:0];
  assign query_wdata = entry_word[54:0];
  assign best_raddr  = best_idx[8:0];
  assign mode        = mode_q;
  assign debug       = debug_q;
  assign wbs_ack_o   = (state_q == S_ACK);
  assign wbs_dat_o   = (state_q == S_ACK) ? rdata_q : 32'h0;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    lower_d   = lower_q;
    mode_d    = mode_q;
    debug_d   = debug_q;
    served_d  = served_q;
    node_wen  = 1'b0;
    leaf_wen  = 1'b0;
    query_wen = 1'b0;
    best_ren  = 1'b0;
    fsm_start = 1'b0;

    if (!(wbs_cyc_i && wbs_stb_i)) served_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdata_d = 32'h0;
        if (wbs_cyc_i && wbs_stb_i && !served_q) begin
          adr_d   = wbs_adr_i;
          dat_d   = wbs_dat_i;
          we_d    = wbs_we_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_ACK;
        rdata_d = 32'h0;
        if (we_q) begin
          if (adr_q == MODE_ADDR) begin
            mode_d = dat_q[0];
          end else if (adr_q == DEBUG_ADDR) begin
            debug_d = dat_q[0];
          end else if (adr_q == FSM_START_ADDR) begin
            fsm_start = dat_q[0] & ~fsm_busy;
          end else if (in_node) begin
            node_wen = node_ok & ~fsm_busy;
          end else if (in_leaf || in_query) begin
            // Any upper-half write consumes the buffer, even when dropped.
            if (adr_q[2]) begin
              lower_d   = 32'h0;
              leaf_wen  = in_leaf  & leaf_ok  & ~fsm_busy;
              query_wen = in_query & query_ok & ~fsm_busy;
            end else if (!fsm_busy && ((in_leaf && leaf_ok) || (in_query && query_ok))) begin
              lower_d = dat_q;
            end
          end
        end else begin
          if (adr_q == MODE_ADDR) begin
            rdata_d = {31'h0, mode_q};
          end else if (adr_q == DEBUG_ADDR) begin
            rdata_d = {31'h0, debug_q};
          end else if (adr_q == DONE_ADDR) begin
            rdata_d = {31'h0, fsm_done};
          end else if (adr_q == FSM_BUSY_ADDR) begin
            rdata_d = {31'h0, fsm_busy};
          end else if (in_best && best_ok) begin
            best_ren = 1'b1;
            state_d  = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        rdata_d = {{(32-DATA_WIDTH){1'b0}}, best_rdata};
        state_d = S_ACK;
      end
      S_ACK: begin
        served_d = wbs_cyc_i & wbs_stb_i;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      we_q     <= 1'b0;
      rdata_q  <= 32'h0;
      lower_q  <= 32'h0;
      mode_q   <= 1'b0;
      debug_q  <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      lower_q  <= lower_d;
      mode_q   <= mode_d;
      debug_q  <= debug_d;
      served_q <= served_d;
    end
  end

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
`timescale 1ns/1ps
module tb_wbs_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        node_wen, leaf_wen, query_wen, best_ren;
  logic [5:0]  node_waddr;
  logic [21:0] node_wdata;
  logic [8:0]  leaf_waddr, query_waddr, best_raddr;
  logic [63:0] leaf_wdata;
  logic [54:0] query_wdata;
  logic [10:0] best_rdata = 11'h0;
  logic        mode, debug, fsm_start;
  logic        fsm_busy = 1'b0, fsm_done = 1'b0;

  int checks = 0;
  int failures = 0;

  // Per-transaction observations (cycle numbers counted from the request cycle N).
  int          ack_cyc, ack_cnt, wen_cyc, ren_cyc, start_cyc;
  int          node_cnt, leaf_cnt, query_cnt, ren_cnt, start_cnt;
  logic [31:0] rd_dat;
  logic [5:0]  node_a;
  logic [21:0] node_d;
  logic [8:0]  leaf_a, query_a, best_a;
  logic [63:0] leaf_d;
  logic [54:0] query_d;
  logic        dat_leak = 1'b0;

  wbs_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .node_wen(node_wen), .node_waddr(node_waddr), .node_wdata(node_wdata),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wdata(leaf_wdata),
    .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
    .best_ren(best_ren), .best_raddr(best_raddr), .best_rdata(best_rdata),
    .mode(mode), .debug(debug), .fsm_start(fsm_start),
    .fsm_busy(fsm_busy), .fsm_done(fsm_done)
  );

  always #5 clk = ~clk;

  // Best-match SRAM model: entry 7 holds 11'h2A5, others hold their index.
  always @(posedge clk)
    if (best_ren) best_rdata <= (best_raddr == 9'd7) ? 11'h2A5 : {2'b00, best_raddr};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One single-beat cycle; stb stays high for 'hold' cycles after the ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int hold);
    int drop_at;
    ack_cyc = 0; ack_cnt = 0; wen_cyc = 0; ren_cyc = 0; start_cyc = 0;
    node_cnt = 0; leaf_cnt = 0; query_cnt = 0; ren_cnt = 0; start_cnt = 0;
    rd_dat = 32'hFFFF_FFFF;
    drop_at = -1;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        ack_cnt++;
        if (ack_cyc == 0) begin
          ack_cyc = c;
          rd_dat  = wbs_dat_o;
          drop_at = c + hold;
        end
      end else if (wbs_dat_o != 32'h0) begin
        dat_leak = 1'b1;
      end
      if (node_wen)  begin node_cnt++;  wen_cyc = c; node_a = node_waddr; node_d = node_wdata; end
      if (leaf_wen)  begin leaf_cnt++;  wen_cyc = c; leaf_a = leaf_waddr; leaf_d = leaf_wdata; end
      if (query_wen) begin query_cnt++; wen_cyc = c; query_a = query_waddr; query_d = query_wdata; end
      if (best_ren)  begin ren_cnt++;   ren_cyc = c; best_a = best_raddr; end
      if (fsm_start) begin start_cnt++; start_cyc = c; end
      if (c == drop_at) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ack",   {63'h0, wbs_ack_o}, 64'h0);
    check_eq("rst_dat",   {32'h0, wbs_dat_o}, 64'h0);
    check_eq("rst_strb",  {59'h0, node_wen, leaf_wen, query_wen, best_ren, fsm_start}, 64'h0);
    check_eq("rst_regs",  {62'h0, mode, debug}, 64'h0);
    check_eq("rst_addr",  {31'h0, node_waddr, leaf_waddr, query_waddr, best_raddr}, 64'h0);
    rst_n = 1'b1;

    // Control registers
    wb_xfer(1'b1, 32'h3000_0004, 32'h1, 0);
    check_eq("dbg_wr_ack_cyc", ack_cyc, 2);
    check_eq("dbg_wr_ack_cnt", ack_cnt, 1);
    check_eq("debug_bit", {63'h0, debug}, 64'h1);
    wb_xfer(1'b1, 32'h3000_0000, 32'h1, 0);
    check_eq("mode_bit", {63'h0, mode}, 64'h1);
    check_eq("mode_wr_ack_cyc", ack_cyc, 2);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 0);
    check_eq("dbg_rd", rd_dat, 32'h1);
    check_eq("dbg_rd_ack_cyc", ack_cyc, 2);
    wb_xfer(1'b0, 32'h3000_0000, 32'h0, 0);
    check_eq("mode_rd", rd_dat, 32'h1);

    // Node load, stb held past the ack: still exactly one ack and one strobe
    wb_xfer(1'b1, 32'h3004_0001, 32'h0001_B801, 3);
    check_eq("node_cnt", node_cnt, 1);
    check_eq("node_wen_cyc", wen_cyc, 1);
    check_eq("node_addr", node_a, 6'd1);
    check_eq("node_data", node_d, 22'h1B801);
    check_eq("node_ack_cyc", ack_cyc, 2);
    check_eq("node_ack_cnt", ack_cnt, 1);
    wb_xfer(1'b1, 32'h3004_0040, 32'h5, 0);
    check_eq("node_oor_cnt", node_cnt, 0);
    check_eq("node_oor_ack", ack_cnt, 1);

    // Leaf pack
    wb_xfer(1'b1, 32'h3002_0018, 32'hAAAA_5555, 0);
    check_eq("leaf_lo_cnt", leaf_cnt, 0);
    check_eq("leaf_lo_ack", ack_cnt, 1);
    wb_xfer(1'b1, 32'h3002_001C, 32'h0123_4567, 0);
    check_eq("leaf_hi_cnt", leaf_cnt, 1);
    check_eq("leaf_addr", leaf_a, 9'd3);
    check_eq("leaf_data", leaf_d, 64'h0123_4567_AAAA_5555);
    check_eq("leaf_wen_cyc", wen_cyc, 1);

    // Query: upper with no lower, last valid index, first invalid index
    wb_xfer(1'b1, 32'h3001_0004, 32'h0000_0FFF, 0);
    check_eq("qry_nolo_cnt", query_cnt, 1);
    check_eq("qry_nolo_addr", query_a, 9'd0);
    check_eq("qry_nolo_data", query_d, 55'h0FFF_0000_0000);
    wb_xfer(1'b1, 32'h3001_0F68, 32'h1234_5678, 0);
    wb_xfer(1'b1, 32'h3001_0F6C, 32'h7FFF_FFFF, 0);
    check_eq("qry_493_cnt", query_cnt, 1);
    check_eq("qry_493_addr", query_a, 9'd493);
    check_eq("qry_493_data", query_d, 55'h7F_FFFF_1234_5678);
    wb_xfer(1'b1, 32'h3001_0F74, 32'h1, 0);
    check_eq("qry_494_cnt", query_cnt, 0);
    check_eq("qry_494_ack", ack_cnt, 1);

    // Best reads
    wb_xfer(1'b0, 32'h3003_001C, 32'h0, 0);
    check_eq("best_ren_cnt", ren_cnt, 1);
    check_eq("best_ren_cyc", ren_cyc, 1);
    check_eq("best_raddr", best_a, 9'd7);
    check_eq("best_ack_cyc", ack_cyc, 3);
    check_eq("best_rd", rd_dat, 32'h0000_02A5);
    wb_xfer(1'b0, 32'h3003_07B4, 32'h0, 0);
    check_eq("best_493_rd", rd_dat, 32'h0000_01ED);
    wb_xfer(1'b0, 32'h3003_07B8, 32'h0, 0);
    check_eq("best_494_ren", ren_cnt, 0);
    check_eq("best_494_rd", rd_dat, 32'h0);
    check_eq("best_494_ack", ack_cnt, 1);

    // Start / busy
    wb_xfer(1'b1, 32'h3000_000C, 32'h1, 0);
    check_eq("start_cnt", start_cnt, 1);
    check_eq("start_cyc", start_cyc, 1);
    check_eq("start_ack_cyc", ack_cyc, 2);
    wb_xfer(1'b1, 32'h3000_000C, 32'h0, 0);
    check_eq("start_d0_cnt", start_cnt, 0);
    fsm_busy = 1'b1;
    fsm_done = 1'b1;
    wb_xfer(1'b1, 32'h3000_000C, 32'h1, 0);
    check_eq("start_busy_cnt", start_cnt, 0);
    check_eq("start_busy_ack", ack_cnt, 1);
    wb_xfer(1'b1, 32'h3002_0000, 32'h1111_1111, 0);
    wb_xfer(1'b1, 32'h3002_0004, 32'h2222_2222, 0);
    check_eq("leaf_busy_cnt", leaf_cnt, 0);
    check_eq("leaf_busy_ack", ack_cnt, 1);
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 0);
    check_eq("busy_rd", rd_dat, 32'h1);
    wb_xfer(1'b0, 32'h3000_0008, 32'h0, 0);
    check_eq("done_rd", rd_dat, 32'h1);
    fsm_busy = 1'b0;
    fsm_done = 1'b0;

    // Unmapped / write-only / illegal targets
    wb_xfer(1'b0, 32'h3005_0000, 32'h0, 0);
    check_eq("unmap_ack", ack_cnt, 1);
    check_eq("unmap_rd", rd_dat, 32'h0);
    wb_xfer(1'b1, 32'h3003_0000, 32'hFFFF_FFFF, 0);
    check_eq("best_wr_strb", node_cnt + leaf_cnt + query_cnt + ren_cnt, 0);
    check_eq("best_wr_ack", ack_cnt, 1);
    wb_xfer(1'b0, 32'h3002_0000, 32'h0, 0);
    check_eq("leaf_rd", rd_dat, 32'h0);

    // Reset mid-transaction: strobe and ack vanish at once, buffer and regs clear
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3004_0002; wbs_dat_i = 32'h3;
    @(negedge clk);
    check_eq("mid_wen_pre", {63'h0, node_wen}, 64'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_wen_rst", {63'h0, node_wen}, 64'h0);
    check_eq("mid_regs_rst", {62'h0, mode, debug}, 64'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    check_eq("mid_ack_rst", {63'h0, wbs_ack_o}, 64'h0);
    rst_n = 1'b1;
    wb_xfer(1'b1, 32'h3002_0008, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(1'b1, 32'h3002_000C, 32'h5, 0);
    check_eq("buf_rst_addr", leaf_a, 9'd1);
    check_eq("buf_rst_data", leaf_d, 64'h0000_0005_0000_0000);

    check_eq("dat_zero_no_ack", {63'h0, dat_leak}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
